// File: rtl/ram_wr_arb_pkg.sv
// ram_wr_arb_pkg -- shared types for the RAM write arbiter.
//   state_e     : arbiter FSM state (SCRUB clears the RAM, ARB serves requesters)
//   req_idx_e   : requester index, used for the round-robin "last granted" pointer
//   RESET_STATE : state entered on reset; SCRUB only when RAM_WR_ARB_SCRUB_EN is defined
package ram_wr_arb_pkg;

  typedef enum logic {
    SCRUB = 1'b0,
    ARB   = 1'b1
  } state_e;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_idx_e;

`ifdef RAM_WR_ARB_SCRUB_EN
  localparam state_e RESET_STATE = SCRUB;
`else
  localparam state_e RESET_STATE = ARB;
`endif

endpackage

// File: rtl/ram_wr_arb_rr_arb2.sv
// rr_arb2 -- two-way round-robin grant, purely combinational.
//   valid_i [1:0] : request valids (bit n = requester n)
//   last_i        : requester granted most recently
//   grant_o [1:0] : one-hot grant (all zero when nothing is valid)
// A sole valid always wins; on a tie the requester not granted last wins.
module rr_arb2
  import ram_wr_arb_pkg::*;
(
  input  logic [1:0] valid_i,
  input  req_idx_e   last_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = valid_i;
    if (valid_i == 2'b11) begin
      grant_o = (last_i == REQ1) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/ram_wr_arb.sv
// ram_wr_arb -- arbitrates two write requesters onto one RAM write port, with
// an optional post-reset scrub that fills every entry with fill_p.
//   clk_i, reset_i              : clock, synchronous active-high reset
//   reqN_valid_i/addr_i/data_i  : requester N write request (N = 0, 1)
//   reqN_ready_o                : requester N accepted this cycle (combinational)
//   ram_wr_valid_o/addr_o/data_o: registered RAM write port, one cycle after handshake
//   busy_o                      : high while scrubbing; requesters are blocked
// Build option: define RAM_WR_ARB_SCRUB_EN to include the SCRUB state, the address
// counter and the fill path. Without it the block is a plain arbiter and busy_o is 0.
module ram_wr_arb
  import ram_wr_arb_pkg::*;
#(
  parameter int unsigned           width_p   = 8,
  parameter int unsigned           depth_p   = 8,
  parameter logic [width_p-1:0]    fill_p    = '0,
  localparam int unsigned          addr_w_lp = (depth_p > 1) ? $clog2(depth_p) : 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 req0_valid_i,
  input  logic [addr_w_lp-1:0] req0_addr_i,
  input  logic [width_p-1:0]   req0_data_i,
  output logic                 req0_ready_o,
  input  logic                 req1_valid_i,
  input  logic [addr_w_lp-1:0] req1_addr_i,
  input  logic [width_p-1:0]   req1_data_i,
  output logic                 req1_ready_o,
  output logic                 ram_wr_valid_o,
  output logic [addr_w_lp-1:0] ram_wr_addr_o,
  output logic [width_p-1:0]   ram_wr_data_o,
  output logic                 busy_o
);

  state_e                 state_q, state_d;
  req_idx_e               last_q, last_d;
  logic                   wr_valid_q, wr_valid_d;
  logic [addr_w_lp-1:0]   wr_addr_q, wr_addr_d;
  logic [width_p-1:0]     wr_data_q, wr_data_d;

  logic                   arb_en;
  logic [1:0]             req_valid;
  logic [1:0]             grant;

  // Readies must be low during reset and outside ARB, so mask the valids
  // before they reach the arbiter rather than masking the grant afterwards.
  assign arb_en    = (state_q == ARB) && !reset_i;
  assign req_valid = {req1_valid_i, req0_valid_i} & {2{arb_en}};

  rr_arb2 u_rr_arb2 (
    .valid_i (req_valid),
    .last_i  (last_q),
    .grant_o (grant)
  );

  assign req0_ready_o = grant[0];
  assign req1_ready_o = grant[1];

`ifdef RAM_WR_ARB_SCRUB_EN
  localparam logic [addr_w_lp-1:0] last_addr_lp = addr_w_lp'(depth_p - 1);
  logic [addr_w_lp-1:0] count_q, count_d;
  assign busy_o = (state_q == SCRUB);
`else
  logic unused_fill;
  assign unused_fill = ^fill_p;
  assign busy_o      = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
`ifdef RAM_WR_ARB_SCRUB_EN
    count_d    = count_q;
`endif
    case (state_q)
      ARB: begin
        // Pointer moves only on an actual grant; idle cycles keep it.
        if (grant[0]) begin
          wr_valid_d = 1'b1;
          wr_addr_d  = req0_addr_i;
          wr_data_d  = req0_data_i;
          last_d     = REQ0;
        end else if (grant[1]) begin
          wr_valid_d = 1'b1;
          wr_addr_d  = req1_addr_i;
          wr_data_d  = req1_data_i;
          last_d     = REQ1;
        end
      end
`ifdef RAM_WR_ARB_SCRUB_EN
      SCRUB: begin
        wr_valid_d = 1'b1;
        wr_addr_d  = count_q;
        wr_data_d  = fill_p;
        // Compare against depth_p-1 instead of relying on wrap so a
        // non-power-of-two depth stops exactly at the last entry.
        if (count_q == last_addr_lp) begin
          count_d = '0;
          state_d = ARB;
        end else begin
          count_d = count_q + addr_w_lp'(1);
        end
      end
`endif
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= RESET_STATE;
      last_q     <= REQ1;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
`ifdef RAM_WR_ARB_SCRUB_EN
      count_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
`ifdef RAM_WR_ARB_SCRUB_EN
      count_q    <= count_d;
`endif
    end
  end

  assign ram_wr_valid_o = wr_valid_q;
  assign ram_wr_addr_o  = wr_addr_q;
  assign ram_wr_data_o  = wr_data_q;

endmodule
